voice_allocator: RTL and testbench
==================================

// Module: voice_allocator
//
// PURPOSE
// Schedules a stream of (note, duration) requests onto NUM_VOICES note_player instances.
// - Picks a free voice and pulses that voice's load_new_note with the note.
// - Counts each voice's duration down on beat ticks from beat_generator.
// - Loads a rest (note 0) into a voice when its duration expires, freeing the voice.
// Sits between the song reader and the bank of note_players.
//
// PARAMETERS
// NUM_VOICES  3  number of note_player voices driven
// NOTE_WIDTH  6  note code width; code 0 = rest
// DUR_WIDTH   6  duration width, counted in beats
//
// PORTS
// clk             in   1                     system clock
// reset           in   1                     synchronous, active-high reset
// play_enable     in   1                     high: durations count; low: counters frozen
// beat            in   1                     one-cycle beat tick
// new_note_valid  in   1                     request present
// new_note        in   NOTE_WIDTH            requested note
// new_duration    in   DUR_WIDTH             requested length in beats
// new_note_ready  out  1                     request accepted this cycle when valid&ready
// note_to_load    out  NUM_VOICES*NOTE_WIDTH packed; voice v = [v*NOTE_WIDTH +: NOTE_WIDTH]
// load_new_note   out  NUM_VOICES            one-cycle load strobe per voice
// voice_active    out  NUM_VOICES            voice currently holding a sounding note
// all_idle        out  1                     no voice active
//
// BEHAVIOUR
// Reset values:
// - Duration counters = 0; voice_active = 0; load_new_note = 0; note_to_load = 0.
// - new_note_ready = 0 while reset is high; all_idle = 1; steal pointer = 0.
// Free voice: voice_active[v] == 0, evaluated from the registered state only.
// new_note_ready: combinational; = (any free voice) & ~reset.
// Accept (new_note_valid & new_note_ready), selected voice = lowest-index free voice v:
// - next cycle: note_to_load[v] = new_note, load_new_note[v] = 1 for exactly 1 cycle.
// - next cycle: voice_active[v] = 1; counter[v] = new_duration.
// Zero duration: a request with new_duration == 0 is accepted and dropped.
// - No load, no state change.
// Countdown: on beat & play_enable, every active voice with counter > 0 decrements by 1.
// Expiry: counter steps 1 -> 0. Next cycle:
// - voice_active[v] = 0.
// - note_to_load[v] = 0 and load_new_note[v] = 1 for 1 cycle (rest load).
// play_enable low: counters hold. Accepts and loads still proceed.
// Accept and beat in the same cycle: the newly loaded voice takes new_duration undecremented.
// - Other voices decrement normally.
// Expiry and accept in the same cycle: the expiring voice is still busy that cycle and is not chosen.
// - It becomes free the following cycle.
// Several voices may expire on the same beat; all strobe together.
// all_idle = ~|voice_active.
// Reset mid-operation: everything returns to reset values on the next edge.
// - No rest loads are issued.
// - In-flight strobes are dropped.
//
// CONFIGURATION
// VOICE_STEAL_EN undefined:
// - All voices busy -> new_note_ready = 0; the requester waits (backpressure).
// VOICE_STEAL_EN defined:
// - new_note_ready = ~reset always.
// - If no voice is free, the request goes to the voice at the steal pointer.
//   That voice is reloaded with the new note and duration, with no rest load.
//   The pointer then increments modulo NUM_VOICES.
// - If that stolen voice is also expiring in the same cycle, the steal wins: only the new-note load occurs.
// - The pointer is untouched when a free voice exists.
//
// TESTING
// 1. Reset for 2 cycles -> all outputs at reset values, all_idle = 1, new_note_ready = 0 during reset.
// 2. Single note: valid with note 1, duration 2; 3 beats at play_enable = 1.
//    -> Next cycle: load_new_note = 3'b001, voice0 = 1.
//    -> Cycle after the 2nd beat: rest strobe on voice0, all_idle = 1.
// 3. Three back-to-back requests (notes 1, 22, 40; duration 4).
//    -> Voices 0, 1, 2 are loaded in order; then new_note_ready = 0 (steal off).
//    -> A 4th request waits until the first expiry, then goes to voice 0.
// 4. play_enable = 0 during 5 beats -> counters unchanged, no rest loads.
//    -> Re-enable: expiry happens after the remaining beats.
// 5. Accept coincident with a beat -> the new voice's counter equals new_duration.
//    Expiry coincident with a request -> the request goes to another free voice or waits one cycle.
// 6. VOICE_STEAL_EN with 3 busy voices; 4th request with note 9.
//    -> Accepted; voice 0 is loaded with 9; steal pointer = 1.
//    -> A 5th request goes to voice 1.

Source files
------------

// File: rtl/voice_allocator.sv
// voice_allocator: schedules (note, duration) requests onto a bank of note_player voices.
// A request is placed on the lowest-index free voice, which is strobed with the note and then
// counted down on each enabled beat. When its count expires, the voice gets a rest (note 0) and is freed.
// Optional feature macro: VOICE_STEAL_EN. When it is defined and every voice is busy, a request
// takes over the voice at a round-robin steal pointer instead of waiting.
//
// Handshake: new_note_ready is a combinational function of registered state and reset only.
// A request is taken on any rising edge where new_note_valid & new_note_ready.
// The requester must hold note and duration stable while valid is high and ready is low.
module voice_allocator #(
  parameter int NUM_VOICES = 3,
  parameter int NOTE_WIDTH = 6,
  parameter int DUR_WIDTH  = 6
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             play_enable,
  input  logic                             beat,
  input  logic                             new_note_valid,
  input  logic [NOTE_WIDTH-1:0]            new_note,
  input  logic [DUR_WIDTH-1:0]             new_duration,
  output logic                             new_note_ready,
  output logic [NUM_VOICES*NOTE_WIDTH-1:0] note_to_load,
  output logic [NUM_VOICES-1:0]            load_new_note,
  output logic [NUM_VOICES-1:0]            voice_active,
  output logic                             all_idle
);

  localparam int PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic [DUR_WIDTH-1:0]             r_count [NUM_VOICES];
  logic [NUM_VOICES-1:0]            r_active;
  logic [NUM_VOICES-1:0]            r_load;
  logic [NUM_VOICES*NOTE_WIDTH-1:0] r_note;

  logic                  w_any_free;
  logic [PTR_W-1:0]      w_free_idx;
  logic [PTR_W-1:0]      w_target;
  logic                  w_ready;
  logic                  w_take;
  logic                  w_tick;
  logic [NUM_VOICES-1:0] w_expire;
  logic [NUM_VOICES-1:0] w_sel;

`ifdef VOICE_STEAL_EN
  logic [PTR_W-1:0] r_steal_ptr;
`endif

  // Find the lowest-index free voice, using only registered state.
  always_comb begin
    w_any_free = 1'b0;
    w_free_idx = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!r_active[v]) begin
        w_any_free = 1'b1;
        w_free_idx = PTR_W'(v);
      end
    end
  end

  // Choose the target voice and decide whether the request is taken.
  always_comb begin
`ifdef VOICE_STEAL_EN
    w_ready  = ~reset;
    w_target = w_any_free ? w_free_idx : r_steal_ptr;
`else
    w_ready  = w_any_free & ~reset;
    w_target = w_free_idx;
`endif
    // A zero-duration request completes the handshake but loads nothing.
    w_take = new_note_valid & w_ready & (new_duration != '0);
    w_tick = beat & play_enable;
    for (int v = 0; v < NUM_VOICES; v++) begin
      w_sel[v]    = w_take & (w_target == PTR_W'(v));
      w_expire[v] = w_tick & r_active[v] & (r_count[v] == DUR_WIDTH'(1));
    end
  end

  // Per-voice state. A new note has priority over an expiry on the same voice, so a stolen
  // voice that is expiring this cycle gets only the new-note load and no rest.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_active <= '0;
      r_load   <= '0;
      r_note   <= '0;
      for (int v = 0; v < NUM_VOICES; v++) r_count[v] <= '0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_load[v] <= w_sel[v] | w_expire[v];
        if (w_sel[v]) begin
          r_note[v*NOTE_WIDTH +: NOTE_WIDTH] <= new_note;
          r_active[v]                        <= 1'b1;
          r_count[v]                         <= new_duration;
        end else begin
          if (w_expire[v]) begin
            r_note[v*NOTE_WIDTH +: NOTE_WIDTH] <= '0;
            r_active[v]                        <= 1'b0;
          end
          if (w_tick && r_active[v] && (r_count[v] != '0))
            r_count[v] <= r_count[v] - DUR_WIDTH'(1);
        end
      end
    end
  end

`ifdef VOICE_STEAL_EN
  // The steal pointer advances only when a request actually takes over a busy voice.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_steal_ptr <= '0;
    end else if (w_take && !w_any_free) begin
      if (r_steal_ptr == PTR_W'(NUM_VOICES - 1)) r_steal_ptr <= '0;
      else                                       r_steal_ptr <= r_steal_ptr + PTR_W'(1);
    end
  end
`endif

  // Drive the outputs from the registered state.
  always_comb begin
    new_note_ready = w_ready;
    note_to_load   = r_note;
    load_new_note  = r_load;
    voice_active   = r_active;
    all_idle       = ~|r_active;
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: table-driven directed vectors for voice_allocator (3 voices, 6-bit note
// and duration fields), plus a hand-written sequence in which a request waits under
// backpressure with a bounded wait.
// Each row is applied for one clock. The combinational ready is checked before the edge, and
// the registered outputs are checked 1 ns after the edge.
module tb_voice_allocator;

  localparam int NV = 3;
  localparam int NW = 6;
  localparam int DW = 6;

  logic           clk;
  logic           reset;
  logic           play_enable;
  logic           beat;
  logic           new_note_valid;
  logic [NW-1:0]  new_note;
  logic [DW-1:0]  new_duration;
  logic           new_note_ready;
  logic [NV*NW-1:0] note_to_load;
  logic [NV-1:0]  load_new_note;
  logic [NV-1:0]  voice_active;
  logic           all_idle;

  typedef struct {
    bit          rst;
    bit          pe;
    bit          bt;
    bit          vld;
    logic [5:0]  note;
    logic [5:0]  dur;
    bit          rdy;
    logic [2:0]  load;
    logic [2:0]  act;
    logic [5:0]  n0;
    logic [5:0]  n1;
    logic [5:0]  n2;
  } vec_t;

  vec_t vecs[$];
  int   tests_run;
  int   tests_failed;

  voice_allocator #(.NUM_VOICES(NV), .NOTE_WIDTH(NW), .DUR_WIDTH(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .play_enable    (play_enable),
    .beat           (beat),
    .new_note_valid (new_note_valid),
    .new_note       (new_note),
    .new_duration   (new_duration),
    .new_note_ready (new_note_ready),
    .note_to_load   (note_to_load),
    .load_new_note  (load_new_note),
    .voice_active   (voice_active),
    .all_idle       (all_idle)
  );

  // Clock and bounded run time.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (got running, want finished)");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int idx, input int act_v, input int exp_v);
    tests_run++;
    if (act_v != exp_v) begin
      tests_failed++;
      $display("FAIL %s row %0d: got 0x%0h want 0x%0h", name, idx, act_v, exp_v);
    end
  endtask

  task automatic add(input bit rst, input bit pe, input bit bt, input bit vld,
                     input int note, input int dur, input bit rdy,
                     input int load, input int act, input int n0, input int n1, input int n2);
    vec_t v;
    v.rst = rst; v.pe = pe; v.bt = bt; v.vld = vld;
    v.note = 6'(note); v.dur = 6'(dur); v.rdy = rdy;
    v.load = 3'(load); v.act = 3'(act);
    v.n0 = 6'(n0); v.n1 = 6'(n1); v.n2 = 6'(n2);
    vecs.push_back(v);
  endtask

  task automatic drive(input bit rst, input bit pe, input bit bt, input bit vld,
                       input logic [5:0] note, input logic [5:0] dur);
    @(negedge clk);
    reset          = rst;
    play_enable    = pe;
    beat           = bt;
    new_note_valid = vld;
    new_note       = note;
    new_duration   = dur;
  endtask

  task automatic apply(input int idx, input vec_t v);
    drive(v.rst, v.pe, v.bt, v.vld, v.note, v.dur);
    #1;
    check("ready", idx, int'(new_note_ready), int'(v.rdy));
    @(posedge clk);
    #1;
    check("load", idx, int'(load_new_note), int'(v.load));
    check("active", idx, int'(voice_active), int'(v.act));
    check("idle", idx, int'(all_idle), (v.act == 3'b000) ? 1 : 0);
    check("note0", idx, int'(note_to_load[0*NW +: NW]), int'(v.n0));
    check("note1", idx, int'(note_to_load[1*NW +: NW]), int'(v.n1));
    check("note2", idx, int'(note_to_load[2*NW +: NW]), int'(v.n2));
  endtask

  // Fields: rst pe beat vld note dur | ready load active n0 n1 n2
  task automatic fill_table();
    add(1,0,0,0, 0,0,  0, 0,0, 0,0,0);   // reset, 2 cycles
    add(1,0,0,0, 0,0,  0, 0,0, 0,0,0);
`ifndef VOICE_STEAL_EN
    add(0,1,0,1, 1,2,  1, 1,1, 1,0,0);   // single note on voice 0
    add(0,1,0,0, 0,0,  1, 0,1, 1,0,0);
    add(0,1,1,0, 0,0,  1, 0,1, 1,0,0);   // beat 1: 2->1
    add(0,1,1,0, 0,0,  1, 1,0, 0,0,0);   // beat 2: expiry, rest strobe
    add(0,1,1,0, 0,0,  1, 0,0, 0,0,0);   // beat 3: nothing
    add(0,1,0,1, 1,4,  1, 1,1, 1,0,0);   // three back-to-back requests
    add(0,1,0,1, 22,4, 1, 2,3, 1,22,0);
    add(0,1,0,1, 40,4, 1, 4,7, 1,22,40);
    add(0,1,0,1, 5,3,  0, 0,7, 1,22,40); // fourth request waits
    add(0,1,1,1, 5,3,  0, 0,7, 1,22,40);
    add(0,1,1,1, 5,3,  0, 0,7, 1,22,40);
    add(0,1,1,1, 5,3,  0, 0,7, 1,22,40);
    add(0,1,1,1, 5,3,  0, 7,0, 0,0,0);   // all expire, request still waits
    add(0,1,0,1, 5,3,  1, 1,1, 5,0,0);   // now goes to voice 0
    for (int i = 0; i < 5; i++)
      add(0,0,1,0, 0,0, 1, 0,1, 5,0,0);  // beats with play_enable low: frozen
    add(0,1,1,0, 0,0,  1, 0,1, 5,0,0);   // 3->2
    add(0,1,1,0, 0,0,  1, 0,1, 5,0,0);   // 2->1
    add(0,1,1,0, 0,0,  1, 1,0, 0,0,0);   // expiry
    add(0,1,0,1, 7,2,  1, 1,1, 7,0,0);   // v0 = 2
    add(0,1,1,1, 8,2,  1, 2,3, 7,8,0);   // accept on beat: v1 = 2, v0 -> 1
    add(0,1,1,0, 0,0,  1, 1,2, 0,8,0);   // v0 expires, v1 -> 1
    add(0,1,1,0, 0,0,  1, 2,0, 0,0,0);   // v1 expires
    add(0,1,0,1, 9,1,  1, 1,1, 9,0,0);   // v0 = 1
    add(0,1,1,1, 10,1, 1, 3,2, 0,10,0);  // v0 expiring is busy: request to v1
    add(0,1,0,1, 11,2, 1, 1,3, 11,10,0); // v0 free again
    add(0,1,1,0, 0,0,  1, 2,1, 11,0,0);  // v1 expires, v0 -> 1
    add(0,1,1,0, 0,0,  1, 1,0, 0,0,0);   // v0 expires
    add(0,1,0,1, 12,0, 1, 0,0, 0,0,0);   // zero duration: dropped
    add(0,1,0,1, 13,1, 1, 1,1, 13,0,0);
    add(1,1,1,1, 14,1, 0, 0,0, 0,0,0);   // reset mid-operation
    add(0,1,0,0, 0,0,  1, 0,0, 0,0,0);
`else
    add(0,1,0,1, 1,4,  1, 1,1, 1,0,0);
    add(0,1,0,1, 22,4, 1, 2,3, 1,22,0);
    add(0,1,0,1, 40,4, 1, 4,7, 1,22,40);
    add(0,1,0,1, 9,3,  1, 1,7, 9,22,40); // steal v0, pointer -> 1
    add(0,1,0,1, 17,2, 1, 2,7, 9,17,40); // steal v1, pointer -> 2
    add(0,1,1,0, 0,0,  1, 0,7, 9,17,40); // v0 3->2, v1 2->1, v2 4->3
    add(0,1,1,1, 33,5, 1, 6,5, 9,0,33);  // v1 rests, v2 stolen, pointer -> 0
    add(0,1,0,1, 44,1, 1, 2,7, 9,44,33); // free v1 used, pointer unchanged
    add(0,1,1,1, 50,2, 1, 3,5, 50,0,33); // v0 stolen while expiring: no rest
    add(0,1,0,1, 51,1, 1, 2,7, 50,51,33);
`endif
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    reset          = 1'b1;
    play_enable    = 1'b0;
    beat           = 1'b0;
    new_note_valid = 1'b0;
    new_note       = '0;
    new_duration   = '0;

    fill_table();
    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

`ifndef VOICE_STEAL_EN
    // Hand-written sequence: fill all voices, then hold a request with a beat every cycle
    // until it is taken (bounded). Voices expire after two beats, so the request must land
    // on voice 0 with its own duration.
    begin
      bit taken;
      int waited;
      drive(1,0,0,0, 6'd0, 6'd0);
      @(posedge clk);
      drive(0,1,0,1, 6'd2, 6'd2);
      drive(0,1,0,1, 6'd3, 6'd2);
      drive(0,1,0,1, 6'd4, 6'd2);
      taken  = 1'b0;
      waited = 0;
      while (!taken && waited < 20) begin
        drive(0,1,1,1, 6'd30, 6'd1);
        #1;
        if (new_note_ready) taken = 1'b1;
        else waited++;
      end
      check("wait_taken", 0, int'(taken), 1);
      check("wait_cycles", 0, waited, 2);
      @(posedge clk);
      #1;
      check("wait_load", 0, int'(load_new_note), 1);
      check("wait_note0", 0, int'(note_to_load[0 +: NW]), 30);
      check("wait_active", 0, int'(voice_active), 1);
      drive(0,1,1,0, 6'd0, 6'd0);
      @(posedge clk);
      #1;
      check("wait_rest", 0, int'(load_new_note), 1);
      check("wait_idle", 0, int'(all_idle), 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
